// File: rtl/gcd_arbiter.sv
// Round-robin arbiter and sequencer sharing one GCD engine between NUM_REQ requesters.
// A watchdog aborts engine runs that exceed TIMEOUT cycles and reports them with timeout_err.
module gcd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         result,
  output logic                     timeout_err,
  output logic                     busy,
  output logic [IW-1:0]            grant_id,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_dataa,
  output logic [WIDTH-1:0]         eng_datab,
  output logic                     eng_reset,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant_q;
  logic [WIDTH-1:0]  dataa_q, datab_q;
  logic [WIDTH-1:0]  result_q;
  logic              terr_q;
  logic              abort_q;
  logic [TW-1:0]     wdog_q;

  logic [IW-1:0]     pick;
  logic              any_req;
  logic              timeout_hit;
  int                idx;

  // Scan downward so the closest set bit above the pointer is the last one written.
  always_comb begin
    pick    = ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IW'(idx)]) begin
        pick    = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wdog_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting the next state to the current one keeps this block free of latches.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (eng_done || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = '0;
    eng_start = 1'b0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_RESP)  ack[grant_q] = 1'b1;
    if (state_q == S_START) eng_start = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= IW'(NUM_REQ - 1);
      grant_q  <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      result_q <= '0;
      terr_q   <= 1'b0;
      abort_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            dataa_q <= op_a[int'(pick)*WIDTH +: WIDTH];
            datab_q <= op_b[int'(pick)*WIDTH +: WIDTH];
          end
        end
        S_START: wdog_q <= '0;
        S_WAIT: begin
          if (eng_done) begin
            result_q <= eng_result;
            terr_q   <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            terr_q   <= 1'b1;
            abort_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        S_RESP:  ptr_q <= grant_q;
        default: ;
      endcase
    end
  end

  // The abort pulse is registered so the engine is cleared during the RESP cycle only.
  assign eng_reset   = reset | abort_q;
  assign result      = result_q;
  assign timeout_err = terr_q;
  assign grant_id    = grant_q;
  assign eng_dataa   = dataa_q;
  assign eng_datab   = datab_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD engine and an expected-ack scoreboard.
// The engine never finishes when a=0 and b!=0, which exercises the watchdog.
module tb_gcd_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           timeout_err, busy;
  logic [1:0]     grant_id;
  logic           eng_start, eng_reset, eng_done;
  logic [W-1:0]   eng_dataa, eng_datab, eng_result;

  logic           m_busy, m_done;
  logic [W-1:0]   m_a, m_b, m_res;
  int             m_cnt;
  logic           force_en, f_done;
  logic [W-1:0]   f_res;
  int             cyc;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] res;
    logic         terr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   s_cyc, lat;
  logic prev_d, er_seen;
  bit   seen;

  gcd_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .result(result), .timeout_err(timeout_err), .busy(busy),
    .grant_id(grant_id), .eng_start(eng_start), .eng_dataa(eng_dataa),
    .eng_datab(eng_datab), .eng_reset(eng_reset), .eng_done(eng_done),
    .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Behavioural engine: fixed latency, hangs on a=0, b!=0.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (eng_reset) begin
      m_busy <= 1'b0;
      m_res  <= '0;
    end else if (eng_start) begin
      m_busy <= 1'b1;
      m_a    <= eng_dataa;
      m_b    <= eng_datab;
      m_cnt  <= 4;
    end else if (m_busy && !(m_a == 0 && m_b != 0)) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1;
        m_res  <= gcd(m_a, m_b);
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign eng_done   = force_en ? f_done : m_done;
  assign eng_result = force_en ? f_res  : m_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[id*W +: W] = a;
    op_b[id*W +: W] = b;
  endtask

  task automatic push(input logic [1:0] id, input logic [W-1:0] res, input logic terr);
    sb.push_back('{id, res, terr});
  endtask

  task automatic check_ack(input logic prev_done);
    exp_t       e;
    logic [N-1:0] one;
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      one = 4'b0001 << e.id;
      check("ack_id", ack, one);
      check("result", result, e.res);
      check("timeout_err", timeout_err, e.terr);
      check("done_to_ack", prev_done, !e.terr);
    end
  endtask

  task automatic serve(input int n, input int budget, input bit drop);
    int   got = 0;
    int   k = 0;
    logic prev = 1'b0;
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      if (ack != '0) begin
        check_ack(prev);
        got++;
        if (drop) req = req & ~ack;
      end
      prev = eng_done;
    end
    check("serve_ack_count", got, n);
  endtask

  task automatic wait_start(output int s);
    bit found = 0;
    s = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (eng_start) begin found = 1; s = cyc; end
    end
    check("start_seen", found, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; force_en = 1'b0; f_done = 1'b0; f_res = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    cyc = 0; op_a = '0; op_b = '0;
    reset = 1'b1; req = '0; force_en = 1'b0; f_done = 1'b0; f_res = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_result", result, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_start", eng_start, 0);
    check("rst_dataa", eng_dataa, 0);
    check("rst_datab", eng_datab, 0);
    check("rst_eng_reset", eng_reset, 1);
    reset = 1'b0;
    @(negedge clk);

    // Single request: start latency, operands, result.
    set_op(0, 12, 8); push(0, 4, 0);
    req = 4'b0001;
    @(negedge clk);
    check("t1_start", eng_start, 1);
    check("t1_dataa", eng_dataa, 12);
    check("t1_datab", eng_datab, 8);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_start_pulse", eng_start, 0);
    serve(1, 50, 1);

    // All four at once, dropped after ack.
    do_reset();
    set_op(0, 36, 24); set_op(1, 7, 5); set_op(2, 100, 75); set_op(3, 9, 9);
    push(0, 12, 0); push(1, 1, 0); push(2, 25, 0); push(3, 9, 0);
    req = 4'b1111;
    serve(4, 200, 1);

    // Two requesters held continuously alternate.
    do_reset();
    set_op(0, 12, 8); set_op(2, 21, 14);
    for (int i = 0; i < 4; i++) begin push(0, 4, 0); push(2, 7, 0); end
    req = 4'b0101;
    serve(8, 400, 0);
    req = '0;

    // Watchdog abort, then a normal run on the same requester.
    do_reset();
    set_op(1, 0, 5); push(1, 0, 1);
    req = 4'b0010;
    s_cyc = -1; lat = -1; prev_d = 1'b0; er_seen = 1'b0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (eng_start) s_cyc = cyc;
      if (ack != '0) begin
        seen = 1; lat = cyc - s_cyc; er_seen = eng_reset;
        check_ack(prev_d);
        req = '0;
      end
      prev_d = eng_done;
    end
    check("t4_ack_seen", seen, 1);
    check("t4_latency", lat, TO + 1);
    check("t4_eng_reset_high", er_seen, 1);
    @(negedge clk);
    check("t4_eng_reset_pulse", eng_reset, 0);
    set_op(1, 9, 6); push(1, 3, 0);
    req = 4'b0010;
    serve(1, 50, 1);

    // Reset in the middle of WAIT.
    do_reset();
    set_op(2, 0, 5);
    req = 4'b0100;
    wait_start(s_cyc);
    req = '0;
    repeat (3) @(negedge clk);
    check("t5_busy_wait", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_eng_reset", eng_reset, 1);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_ack", ack, 0);
    check("t5_grant", grant_id, 0);
    reset = 1'b0;
    set_op(0, 36, 24); set_op(3, 9, 9);
    push(0, 12, 0); push(3, 9, 0);
    req = 4'b1001;
    serve(2, 100, 1);

    // Done coincides with the last watchdog cycle: done wins.
    do_reset();
    force_en = 1'b1;
    set_op(0, 0, 5); push(0, 7, 0);
    req = 4'b0001;
    wait_start(s_cyc);
    req = '0;
    repeat (TO) @(negedge clk);
    f_done = 1'b1; f_res = 7;
    @(negedge clk);
    f_done = 1'b0;
    check("t6_ack_seen", ack != '0, 1);
    if (ack != '0) check_ack(1'b1);
    check("t6_eng_reset", eng_reset, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one gcd_ci engine between NUM_REQ requesters. It picks one pending request, captures that requester's operands and pulses the engine start. It then waits for the engine done pulse and returns the result to the granted requester with a one-cycle ack. A watchdog aborts runs that exceed TIMEOUT cycles, for example the non-terminating case a=0, b!=0, and flags them with an error.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
WIDTH, 32, operand and result width; must match the engine.
TIMEOUT, 1024, maximum WAIT cycles before abort; 0 disables the watchdog.
TW, 16, watchdog counter width; TIMEOUT < 2**TW.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  request per requester; held high with operands stable until ack.
op_a  in  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
op_b  in  NUM_REQ*WIDTH  operand B; same packing as op_a.
ack  out  NUM_REQ  one-cycle pulse to the granted requester; result and timeout_err are valid in that cycle.
result  out  WIDTH  GCD result; 0 on timeout.
timeout_err  out  1  high with ack when the run was aborted.
busy  out  1  high in every state except IDLE.
grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
eng_start  out  1  engine start pulse.
eng_dataa  out  WIDTH  engine operand A.
eng_datab  out  WIDTH  engine operand B.
eng_reset  out  1  engine synchronous reset: reset OR abort pulse.
eng_done  in  1  engine done pulse.
eng_result  in  WIDTH  engine result; valid when eng_done is high.

Behaviour:
- The block uses one clock, clk. Reset is synchronous and active-high on port reset.
- Reset state: state=IDLE; ack=0; result=0; timeout_err=0; busy=0; grant_id=0; eng_start=0; eng_dataa=0; eng_datab=0; watchdog=0.
- Reset state, continued: the round-robin pointer is set to NUM_REQ-1, so requester 0 has top priority after reset. eng_reset is high while reset is high.
- FSM has four states: IDLE, START, WAIT and RESP.
- IDLE:
  - If req is non-zero, grant the first set bit searching upward from pointer+1 with wrap-around.
  - Register grant_id and copy that requester's op_a/op_b into eng_dataa/eng_datab, then go to START.
  - If req is all zero, stay in IDLE.
- START: eng_start=1 for exactly this cycle; clear the watchdog; go to WAIT. eng_dataa/eng_datab hold their values until the next grant.
- WAIT, priority order:
  - (1) eng_done=1: latch eng_result into result, set timeout_err=0, go to RESP.
  - (2) TIMEOUT!=0 and watchdog==TIMEOUT-1: set result=0 and timeout_err=1, arm the abort, go to RESP.
  - (3) Otherwise increment the watchdog.
  - If eng_done and the timeout coincide, eng_done wins.
- RESP:
  - ack[grant_id]=1 for exactly this cycle; set pointer=grant_id; go to IDLE.
  - On a timeout, eng_reset is also high (registered) for this cycle only.
- Latency:
  - First req in IDLE at cycle N gives eng_start at N+1.
  - ack follows eng_done by exactly 1 cycle.
  - On a timeout, ack arrives TIMEOUT+1 cycles after the eng_start cycle.
- Back-to-back transactions: a requester must drive req low in the cycle after ack, otherwise it is treated as a new request. Minimum spacing between grants is 4 cycles.
- Req dropped before ack: operands are already captured, so the run completes and ack still pulses.
- eng_done outside WAIT is ignored.
- Reset mid-operation returns immediately to IDLE with no ack.
- Requests arriving while busy are not lost; they are arbitrated on the next IDLE.
- Only one ack bit may ever be high in a cycle.

Test Plan:
1. After reset, req[0]=1 with a=12, b=8 -> eng_start high 1 cycle with eng_dataa=12, eng_datab=8. ack[0] pulses 1 cycle after eng_done with result=4, timeout_err=0.
2. All four req high together after reset, each dropped after its ack, operands (36,24),(7,5),(100,75),(9,9) -> grants in order 0,1,2,3; results 12,1,25,9.
3. req[0] and req[2] re-asserted continuously -> grants alternate 0,2,0,2 for 8 transactions; req[1] and req[3] never acked.
4. TIMEOUT=16, req[1] with a=0, b=5 -> ack[1] 17 cycles after eng_start with timeout_err=1, result=0, eng_reset high 1 cycle. A following req[1] with a=9, b=6 then returns result=3, timeout_err=0.
5. reset asserted 3 cycles into WAIT -> next cycle state=IDLE, busy=0, no ack, eng_reset high. A subsequent simultaneous req[3] and req[0] grants 0 first.
6. Forced eng_done=1 with eng_result=7 in the cycle the watchdog reaches TIMEOUT-1 -> ack with result=7, timeout_err=0, eng_reset stays low.
